bus_bridge_io: RTL

//  Responder end of the CPU data bus (Bus_addr/Bus_we/Bus_wdata -> Bus_rdata).
//  - Decodes each access to either the external DRAM or the memory-mapped I/O page.
//  - Owns the I/O state: LEDs, switches/buttons, 8-digit 7-seg display and a prescaled timer.
//  - Sits between myCPU's MEM stage and the board top.
//  - Reads are zero-latency, because the CPU samples Bus_rdata in the same cycle.

---
 rtl/bus_bridge_io_pkg.sv | 42 ++++
 rtl/defines.vh | 12 +
 rtl/seg7_scan.sv | 57 +++++
 rtl/bus_bridge_io.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/bus_bridge_io_pkg.sv
// Shared types and helpers for the CPU bus responder and its 7-seg scanner.
package bus_bridge_io_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    typedef enum logic [2:0] {
        SEL_DRAM,
        SEL_DIG,
        SEL_TCNT,
        SEL_TDIV,
        SEL_LED,
        SEL_SW,
        SEL_BTN,
        SEL_NONE
    } bus_sel_e;

    // Active-low {dp,g,f,e,d,c,b,a}; decimal point always off.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] s;
        case (nib)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/defines.vh
`ifndef BUS_BRIDGE_IO_DEFINES_VH
`define BUS_BRIDGE_IO_DEFINES_VH

`define IO_PAGE  20'hFFFFF
`define OFF_DIG  12'h000
`define OFF_TCNT 12'h020
`define OFF_TDIV 12'h024
`define OFF_LED  12'h060
`define OFF_SW   12'h070
`define OFF_BTN  12'h078

`endif

// File: rtl/seg7_scan.sv
// Purpose: time-multiplexes a 32-bit value onto eight active-low 7-seg digits.
// Latency: dig_en/seg are registered and change only on a scan-slot wrap.
// Backpressure: none; free-running from reset release.
module seg7_scan
    import bus_bridge_io_pkg::*;
#(
    parameter int SCAN_DIV = 20000
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst,
    input  logic [31:0]           dig_val,
    output logic [NUM_DIGITS-1:0] dig_en,
    output logic [7:0]            seg
);

    localparam int               CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0]      scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d, idx_next;
    logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;
    logic [7:0]            seg_q, seg_d;
    logic                  wrap;

    always_comb begin
        wrap       = (scan_cnt_q == CNT_LAST);
        idx_next   = idx_q + IDX_W'(1);
        scan_cnt_d = wrap ? '0 : scan_cnt_q + CNT_W'(1);
        idx_d      = idx_q;
        dig_en_d   = dig_en_q;
        seg_d      = seg_q;
        // Digit value is sampled at the slot boundary, so a DIG write shows up within one full sweep.
        if (wrap) begin
            idx_d    = idx_next;
            dig_en_d = ~(NUM_DIGITS'(1) << idx_next);
            seg_d    = hex_to_seg(dig_val[{idx_next, 2'b00} +: 4]);
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            scan_cnt_q <= '0;
            idx_q      <= IDX_W'(NUM_DIGITS - 1);
            dig_en_q   <= '1;
            seg_q      <= 8'hFF;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            dig_en_q   <= dig_en_d;
            seg_q      <= seg_d;
        end
    end

    assign dig_en = dig_en_q;
    assign seg    = seg_q;

endmodule

// File: rtl/bus_bridge_io.sv
// Purpose: CPU data-bus responder; decodes DRAM vs I/O page and owns LED/SW/BTN/7-seg/timer state.
// Latency: reads are combinational (zero cycles); writes commit at the posedge with Bus_we high.
// Backpressure: none; every access completes in its own cycle.
`include "defines.vh"

module bus_bridge_io
    import bus_bridge_io_pkg::*;
#(
    parameter int DRAM_AW  = 14,
    parameter int SCAN_DIV = 20000,
    parameter int LED_W    = 24
) (
    input  logic               cpu_clk,
    input  logic               cpu_rst,
    input  logic [31:0]        Bus_addr,
    input  logic               Bus_we,
    input  logic [31:0]        Bus_wdata,
    output logic [31:0]        Bus_rdata,
    output logic [DRAM_AW-1:0] dram_addr,
    output logic               dram_we,
    output logic [31:0]        dram_wdata,
    input  logic [31:0]        dram_rdata,
    input  logic [LED_W-1:0]   sw,
    input  logic [4:0]         btn,
    output logic [LED_W-1:0]   led,
    output logic [7:0]         dig_en,
    output logic [7:0]         seg
);

    bus_sel_e         sel;
    logic [11:0]      io_off;
    logic             wr_dig, wr_tcnt, wr_tdiv, wr_led;
    logic             tick;
    logic             unused_addr_bits;

    logic [31:0]      dig_q, dig_d;
    logic [31:0]      tcnt_q, tcnt_d;
    logic [31:0]      tdiv_q, tdiv_d;
    logic [31:0]      psc_q, psc_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [LED_W-1:0] sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
    logic [4:0]       btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;

    assign io_off           = {Bus_addr[11:2], 2'b00};
    assign unused_addr_bits = ^Bus_addr[1:0];

    always_comb begin
        sel = SEL_DRAM;
        if (Bus_addr[31:12] == `IO_PAGE) begin
            case (io_off)
                `OFF_DIG:  sel = SEL_DIG;
                `OFF_TCNT: sel = SEL_TCNT;
                `OFF_TDIV: sel = SEL_TDIV;
                `OFF_LED:  sel = SEL_LED;
                `OFF_SW:   sel = SEL_SW;
                `OFF_BTN:  sel = SEL_BTN;
                default:   sel = SEL_NONE;
            endcase
        end
    end

    assign wr_dig  = Bus_we && (sel == SEL_DIG);
    assign wr_tcnt = Bus_we && (sel == SEL_TCNT);
    assign wr_tdiv = Bus_we && (sel == SEL_TDIV);
    assign wr_led  = Bus_we && (sel == SEL_LED);

    assign dram_addr  = Bus_addr[DRAM_AW+1:2];
    assign dram_we    = Bus_we && (sel == SEL_DRAM);
    assign dram_wdata = Bus_wdata;

    assign tick = (tdiv_q != 32'd0) && (psc_q == tdiv_q - 32'd1);

    always_comb begin
        dig_d    = wr_dig ? Bus_wdata : dig_q;
        led_d    = wr_led ? Bus_wdata[LED_W-1:0] : led_q;
        tdiv_d   = wr_tdiv ? Bus_wdata : tdiv_q;
        sw_s1_d  = sw;
        sw_s2_d  = sw_s1_q;
        btn_s1_d = btn;
        btn_s2_d = btn_s1_q;

        tcnt_d = tcnt_q;
        if (tdiv_q == 32'd0) begin
            psc_d = 32'd0;
        end else if (tick) begin
            psc_d  = 32'd0;
            tcnt_d = tcnt_q + 32'd1;
        end else begin
            psc_d = psc_q + 32'd1;
        end
        if (wr_tdiv) begin
            psc_d = 32'd0;
        end
        // A software load wins over a same-cycle prescaler tick.
        if (wr_tcnt) begin
            tcnt_d = Bus_wdata;
            psc_d  = 32'd0;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            dig_q    <= '0;
            tcnt_q   <= '0;
            tdiv_q   <= '0;
            psc_q    <= '0;
            led_q    <= '0;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            btn_s1_q <= '0;
            btn_s2_q <= '0;
        end else begin
            dig_q    <= dig_d;
            tcnt_q   <= tcnt_d;
            tdiv_q   <= tdiv_d;
            psc_q    <= psc_d;
            led_q    <= led_d;
            sw_s1_q  <= sw_s1_d;
            sw_s2_q  <= sw_s2_d;
            btn_s1_q <= btn_s1_d;
            btn_s2_q <= btn_s2_d;
        end
    end

    always_comb begin
        case (sel)
            SEL_DRAM: Bus_rdata = dram_rdata;
            SEL_DIG:  Bus_rdata = dig_q;
            SEL_TCNT: Bus_rdata = tcnt_q;
            SEL_TDIV: Bus_rdata = tdiv_q;
            SEL_LED:  Bus_rdata = 32'(led_q);
            SEL_SW:   Bus_rdata = 32'(sw_s2_q);
            SEL_BTN:  Bus_rdata = 32'(btn_s2_q);
            default:  Bus_rdata = 32'd0;
        endcase
    end

    assign led = led_q;

    seg7_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .dig_val (dig_q),
        .dig_en  (dig_en),
        .seg     (seg)
    );

endmodule
